// File: rtl/rsa_modexp_sequencer.sv
// Montgomery-domain square-and-multiply sequencer driving one shared multiplier.
// Define RSA_MODEXP_SKIP_EN to skip MUL ops on zero exponent bits (not constant-time).
module rsa_modexp_sequencer #(
  parameter int MOD_WIDTH = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_msg,
  input  logic [MOD_WIDTH-1:0] i_r2,
  input  logic [EXP_WIDTH-1:0] i_exponent,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_result,
  output logic                 mm_i_valid,
  input  logic                 mm_i_ready,
  output logic [MOD_WIDTH-1:0] mm_a,
  output logic [MOD_WIDTH-1:0] mm_b,
  output logic [MOD_WIDTH-1:0] mm_modulus,
  input  logic                 mm_o_valid,
  output logic                 mm_o_ready,
  input  logic [MOD_WIDTH-1:0] mm_o_result
);

  localparam int KW = $clog2(EXP_WIDTH + 1);
  localparam logic [KW-1:0]        K_LAST = KW'(EXP_WIDTH - 1);
  localparam logic [MOD_WIDTH-1:0] ONE    = MOD_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV_BASE, S_CONV_ONE, S_MUL, S_SQR, S_FINAL, S_OUT
  } state_t;

  typedef enum logic {P_ISSUE, P_WAIT} phase_t;

  state_t r_state, w_state_n;
  phase_t r_phase, w_phase_n;

  logic [MOD_WIDTH-1:0] r_msg, r_r2, r_mod, r_base, r_acc, r_result;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [KW-1:0]        r_k;

  logic                 w_accept, w_done, w_adv, w_skip;
  logic [MOD_WIDTH-1:0] w_reduced;

  assign mm_modulus = r_mod;
  assign o_result   = r_result;
  assign w_reduced  = (mm_o_result >= r_mod) ? (mm_o_result - r_mod) : mm_o_result;

`ifdef RSA_MODEXP_SKIP_EN
  assign w_skip = (r_state == S_MUL) && !r_exp[0];
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_phase <= P_ISSUE;
    end else begin
      r_state <= w_state_n;
      r_phase <= w_phase_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    i_ready    = 1'b0;
    o_valid    = 1'b0;
    mm_i_valid = 1'b0;
    mm_o_ready = 1'b0;
    w_accept   = 1'b0;
    w_done     = 1'b0;
    w_adv      = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          w_accept  = 1'b1;
          w_state_n = S_CONV_BASE;
          w_phase_n = P_ISSUE;
        end
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (o_ready) w_state_n = S_IDLE;
      end
      default: begin
        if (r_phase == P_ISSUE) begin
          if (w_skip) begin
            w_adv = 1'b1;
          end else begin
            mm_i_valid = 1'b1;
            if (mm_i_ready) w_phase_n = P_WAIT;
          end
        end else begin
          mm_o_ready = 1'b1;
          if (mm_o_valid) begin
            w_done = 1'b1;
            w_adv  = 1'b1;
          end
        end
        if (w_adv) begin
          w_phase_n = P_ISSUE;
          case (r_state)
            S_CONV_BASE: w_state_n = S_CONV_ONE;
            S_CONV_ONE:  w_state_n = S_MUL;
            S_MUL:       w_state_n = (r_k == K_LAST) ? S_FINAL : S_SQR;
            S_SQR:       w_state_n = S_MUL;
            default:     w_state_n = S_OUT;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (r_state)
      S_CONV_BASE: begin mm_a = r_msg;  mm_b = r_r2;   end
      S_CONV_ONE:  begin mm_a = ONE;    mm_b = r_r2;   end
      S_MUL:       begin mm_a = r_acc;  mm_b = r_base; end
      S_SQR:       begin mm_a = r_base; mm_b = r_base; end
      S_FINAL:     begin mm_a = r_acc;  mm_b = ONE;    end
      default:     begin mm_a = '0;     mm_b = '0;     end
    endcase
  end

  // The exponent shifts right once per loop step, so bit 0 is always exponent[k].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msg    <= '0;
      r_r2     <= '0;
      r_mod    <= '0;
      r_exp    <= '0;
      r_k      <= '0;
      r_base   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_msg <= i_msg;
        r_r2  <= i_r2;
        r_mod <= i_modulus;
        r_exp <= i_exponent;
        r_k   <= '0;
      end
      if (w_done) begin
        case (r_state)
          S_CONV_BASE: r_base <= mm_o_result;
          S_CONV_ONE:  r_acc  <= mm_o_result;
          S_MUL:       if (r_exp[0]) r_acc <= mm_o_result;
          S_SQR:       r_base <= mm_o_result;
          S_FINAL: begin
            r_acc    <= mm_o_result;
            r_result <= w_reduced;
          end
          default: ;
        endcase
      end
      if (w_adv && (r_state == S_SQR)) begin
        r_k   <= r_k + KW'(1);
        r_exp <= r_exp >> 1;
      end
    end
  end

endmodule
